eth_cmd_axil_master: RTL and testbench

// Converts decoded Ethernet register commands (op, address, data) into single AXI4-Lite

---
 rtl/eth_cmd_axil_master.sv | 180 ++++++++++++++++++
 tb/tb_eth_cmd_axil_master.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_cmd_axil_master.sv
// -----------------------------------------------------------------------------
// eth_cmd_axil_master
//
// Turns decoded Ethernet register commands (op, address, data) into single
// AXI4-Lite transactions on the register slave. It returns read data and
// response status to the command source. Only one command is in flight at a
// time, so there is never any overlap of outstanding transactions.
//
// Ports
//   ACLK, ARESET         clock (rising edge), asynchronous active-high reset
//   cmd_valid/ready      command handshake; cmd_ready is high only when idle
//   cmd_wr/addr/data     1=write, byte address, write data
//   rsp_valid/ready      response handshake; rsp_* are held until consumed
//   rsp_wr/data/resp     echo of cmd_wr, read data (0 for writes and rejects),
//                        AXI response or SLVERR for a locally rejected address
//   M_AXI_*              AXI4-Lite master: AW, W, B, AR and R channels
// -----------------------------------------------------------------------------
module eth_cmd_axil_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS           = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  // command side
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_wr,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_data,
  // response side
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_wr,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]                      rsp_resp,
  // AXI4-Lite write address
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  // AXI4-Lite write data
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  // AXI4-Lite write response
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  // AXI4-Lite read address
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  // AXI4-Lite read data
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_WR_B = 3'd2;
  localparam logic [2:0] S_RD_A = 3'd3;
  localparam logic [2:0] S_RD_R = 3'd4;
  localparam logic [2:0] S_RSP  = 3'd5;

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [2:0] state;

  // Word-aligned and inside the register window. The address is widened
  // first so the bound still works when NUM_REGS*4 does not fit in AW bits.
  function automatic logic addr_legal(input logic [AW-1:0] a);
    logic [31:0] a_ext;
    a_ext = 32'(a);
    return (a[1:0] == 2'b00) && (a_ext < 32'(NUM_REGS * 4));
  endfunction

  assign cmd_ready    = (state == S_IDLE);
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = '1;

  // All handshake outputs are registered, so no READY input reaches a VALID
  // output combinationally. In S_WR each channel's VALID drops on its own
  // handshake; a VALID that is already low marks that channel as done.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state         <= S_IDLE;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_wr        <= 1'b0;
      rsp_data      <= '0;
      rsp_resp      <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            rsp_wr   <= cmd_wr;
            rsp_data <= '0;
            if (!addr_legal(cmd_addr)) begin
              rsp_resp  <= RESP_SLVERR;
              rsp_valid <= 1'b1;
              state     <= S_RSP;
            end else if (cmd_wr) begin
              M_AXI_AWADDR  <= cmd_addr;
              M_AXI_WDATA   <= cmd_data;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state         <= S_WR;
            end else begin
              M_AXI_ARADDR  <= cmd_addr;
              M_AXI_ARVALID <= 1'b1;
              state         <= S_RD_A;
            end
          end
        end
        S_WR: begin
          if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
          if ((!M_AXI_AWVALID || M_AXI_AWREADY) &&
              (!M_AXI_WVALID  || M_AXI_WREADY)) begin
            M_AXI_BREADY <= 1'b1;
            state        <= S_WR_B;
          end
        end
        S_WR_B: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            rsp_resp     <= M_AXI_BRESP;
            rsp_valid    <= 1'b1;
            state        <= S_RSP;
          end
        end
        S_RD_A: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= S_RD_R;
          end
        end
        S_RD_R: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            rsp_data     <= M_AXI_RDATA;
            rsp_resp     <= M_AXI_RRESP;
            rsp_valid    <= 1'b1;
            state        <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Only a 32-bit data path is supported.
  if (DW != 32) begin : g_bad_width
    $error("eth_cmd_axil_master supports only C_M_AXI_DATA_WIDTH = 32");
  end

endmodule

// File: tb/tb_eth_cmd_axil_master.sv
module tb_eth_cmd_axil_master;

  localparam int AW = 8;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_wr;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic        M_AXI_AWVALID, M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY;
  logic        M_AXI_ARVALID, M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  int n_checks = 0;
  int n_fail   = 0;

  // slave knobs (written by the stimulus process only)
  int       aw_delay = 0;
  logic     b_hold   = 1'b0;
  logic [1:0] slv_resp = 2'b00;

  // slave state and monitors (written by the slave process only)
  logic [31:0] mem [4];
  int   aw_wait, b_cnt = 0, awv_cyc = 0, wv_cyc = 0, any_v = 0;
  logic got_aw, got_w;
  logic [AW-1:0] aw_a, p_awaddr, p_araddr;
  logic [31:0] w_d, p_wdata;
  logic p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr;

  always #5 ACLK = ~ACLK;

  eth_cmd_axil_master #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(32),
    .NUM_REGS(4)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // AXI4-Lite register slave, driven on the falling edge. A handshake is
  // recognised one half-cycle after the rising edge it happened on, using the
  // valid/ready levels captured at the previous falling edge.
  always @(negedge ACLK) begin
    if (ARESET) begin
      M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
      M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0;
      M_AXI_BRESP = 2'b00;  M_AXI_RRESP = 2'b00;
      aw_wait = 0; got_aw = 1'b0; got_w = 1'b0; aw_a = '0; w_d = '0;
      p_awaddr = '0; p_araddr = '0; p_wdata = '0;
      {p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr} = '0;
      for (int i = 0; i < 4; i++) mem[i] = '0;
    end else begin
      if (p_awv && !p_awr) check_val("awvalid_hold", {31'b0, M_AXI_AWVALID}, 32'd1);
      if (p_wv  && !p_wr)  check_val("wvalid_hold",  {31'b0, M_AXI_WVALID},  32'd1);
      if (p_arv && !p_arr) check_val("arvalid_hold", {31'b0, M_AXI_ARVALID}, 32'd1);
      if (p_awv && p_awr) begin got_aw = 1'b1; aw_a = p_awaddr; M_AXI_AWREADY = 1'b0; aw_wait = 0; end
      if (p_wv && p_wr)   begin got_w = 1'b1;  w_d = p_wdata;   M_AXI_WREADY = 1'b0; end
      if (p_bv && p_br)   begin M_AXI_BVALID = 1'b0; b_cnt++; end
      if (p_rv && p_rr)   M_AXI_RVALID = 1'b0;
      if (p_arv && p_arr) begin
        M_AXI_ARREADY = 1'b0;
        M_AXI_RDATA   = mem[p_araddr[3:2]];
        M_AXI_RRESP   = slv_resp;
        M_AXI_RVALID  = 1'b1;
      end
      if (got_aw && got_w && !b_hold && !M_AXI_BVALID) begin
        mem[aw_a[3:2]] = w_d;
        M_AXI_BRESP    = slv_resp;
        M_AXI_BVALID   = 1'b1;
        got_aw = 1'b0; got_w = 1'b0;
      end
      if (M_AXI_AWVALID && !M_AXI_AWREADY) begin
        if (aw_wait >= aw_delay) M_AXI_AWREADY = 1'b1;
        else aw_wait++;
      end
      if (M_AXI_WVALID && !M_AXI_WREADY)   M_AXI_WREADY  = 1'b1;
      if (M_AXI_ARVALID && !M_AXI_ARREADY) M_AXI_ARREADY = 1'b1;
      awv_cyc += int'(M_AXI_AWVALID);
      wv_cyc  += int'(M_AXI_WVALID);
      any_v   += int'(M_AXI_AWVALID | M_AXI_WVALID | M_AXI_ARVALID);
      p_awv = M_AXI_AWVALID; p_awr = M_AXI_AWREADY; p_awaddr = M_AXI_AWADDR;
      p_wv  = M_AXI_WVALID;  p_wr  = M_AXI_WREADY;  p_wdata  = M_AXI_WDATA;
      p_bv  = M_AXI_BVALID;  p_br  = M_AXI_BREADY;
      p_arv = M_AXI_ARVALID; p_arr = M_AXI_ARREADY; p_araddr = M_AXI_ARADDR;
      p_rv  = M_AXI_RVALID;  p_rr  = M_AXI_RREADY;
    end
  end

  // Issue one command, wait for its response, optionally stall the consumer
  // for 'hold' cycles, then consume it. lat counts rising edges after the
  // accepting edge until rsp_valid is seen; fv = {AWVALID,WVALID,ARVALID}
  // just after the accepting edge.
  task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [31:0] data,
                        input int hold, output logic [31:0] rd, output logic [1:0] rr,
                        output logic rw, output int lat, output logic [2:0] fv);
    int cyc;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_data = data;
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin @(posedge ACLK); #1; cyc++; end
    if (!cmd_ready) check_val("cmd_ready_timeout", 32'd0, 32'd1);
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
    fv = {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID};
    lat = 0;
    while (!rsp_valid && lat < 100) begin @(posedge ACLK); #1; lat++; end
    if (!rsp_valid) check_val("rsp_timeout", 32'd0, 32'd1);
    rd = rsp_data; rr = rsp_resp; rw = rsp_wr;
    for (int i = 0; i < hold; i++) begin
      @(posedge ACLK); #1;
      check_val("hold_valid", {31'b0, rsp_valid}, 32'd1);
      check_val("hold_data", rsp_data, rd);
      check_val("hold_resp", {30'b0, rsp_resp}, {30'b0, rr});
      check_val("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge ACLK); #1;
    rsp_ready = 1'b0;
    check_val("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_val("post_cmd_ready", {31'b0, cmd_ready}, 32'd1);
  endtask

  logic [31:0] rd;
  logic [1:0]  rr;
  logic        rw;
  int          lat, cyc, snap_aw, snap_w, snap_b, snap_any;
  logic [2:0]  fv;

  initial begin
    // reset state
    repeat (2) @(posedge ACLK);
    #1;
    check_val("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check_val("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_val("rst_valids", {29'b0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 32'd0);
    check_val("rst_readies", {30'b0, M_AXI_BREADY, M_AXI_RREADY}, 32'd0);
    check_val("rst_rsp_data", rsp_data, 32'd0);
    check_val("rst_wstrb", {28'b0, M_AXI_WSTRB}, 32'hF);
    check_val("rst_prot", {26'b0, M_AXI_AWPROT, M_AXI_ARPROT}, 32'd0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;

    // 1) single write, best-case latency
    do_cmd(1'b1, 8'h00, 32'h1, 0, rd, rr, rw, lat, fv);
    check_val("t1_first_valids", {29'b0, fv}, 32'b110);
    check_val("t1_latency", lat, 32'd2);
    check_val("t1_resp", {30'b0, rr}, 32'd0);
    check_val("t1_wr", {31'b0, rw}, 32'd1);
    check_val("t1_data", rd, 32'd0);
    check_val("t1_wstrb", {28'b0, M_AXI_WSTRB}, 32'hF);

    // 2) write four registers, read them back
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b1, AW'(4 * i), 32'(i + 1), 0, rd, rr, rw, lat, fv);
      check_val("t2_wr_resp", {30'b0, rr}, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b0, AW'(4 * i), 32'hDEAD_BEEF, 0, rd, rr, rw, lat, fv);
      check_val("t2_rd_data", rd, 32'(i + 1));
      check_val("t2_rd_resp", {30'b0, rr}, 32'd0);
      check_val("t2_rd_wr", {31'b0, rw}, 32'd0);
      check_val("t2_rd_latency", lat, 32'd2);
      check_val("t2_rd_first_valids", {29'b0, fv}, 32'b001);
    end

    // 3) AWREADY three cycles late, WREADY immediate
    aw_delay = 3;
    snap_aw = awv_cyc; snap_w = wv_cyc; snap_b = b_cnt;
    do_cmd(1'b1, 8'h04, 32'h55, 0, rd, rr, rw, lat, fv);
    aw_delay = 0;
    check_val("t3_awvalid_cycles", awv_cyc - snap_aw, 32'd4);
    check_val("t3_wvalid_cycles", wv_cyc - snap_w, 32'd1);
    check_val("t3_b_count", b_cnt - snap_b, 32'd1);
    check_val("t3_latency", lat, 32'd5);
    check_val("t3_resp", {30'b0, rr}, 32'd0);

    // 4) local rejects: misaligned and out of range
    snap_any = any_v;
    do_cmd(1'b1, 8'h02, 32'h99, 0, rd, rr, rw, lat, fv);
    check_val("t4a_resp", {30'b0, rr}, 32'b10);
    check_val("t4a_data", rd, 32'd0);
    check_val("t4a_wr", {31'b0, rw}, 32'd1);
    check_val("t4a_latency", lat, 32'd0);
    do_cmd(1'b0, 8'h10, 32'h0, 0, rd, rr, rw, lat, fv);
    check_val("t4b_resp", {30'b0, rr}, 32'b10);
    check_val("t4b_data", rd, 32'd0);
    check_val("t4b_wr", {31'b0, rw}, 32'd0);
    check_val("t4_no_axi_valid", any_v - snap_any, 32'd0);

    // 5) response stalled five cycles after a read of 0x8
    do_cmd(1'b0, 8'h08, 32'h0, 5, rd, rr, rw, lat, fv);
    check_val("t5_data", rd, 32'd3);
    check_val("t5_resp", {30'b0, rr}, 32'd0);

    // slave error codes are passed through
    slv_resp = 2'b01;
    do_cmd(1'b1, 8'h0C, 32'h66, 0, rd, rr, rw, lat, fv);
    check_val("slv_bresp", {30'b0, rr}, 32'b01);
    do_cmd(1'b0, 8'h0C, 32'h0, 0, rd, rr, rw, lat, fv);
    check_val("slv_rresp", {30'b0, rr}, 32'b01);
    check_val("slv_rdata", rd, 32'h66);
    slv_resp = 2'b00;

    // 6) reset while waiting for B
    b_hold = 1'b1;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h00; cmd_data = 32'h77;
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
    cyc = 0;
    while (!M_AXI_BREADY && cyc < 20) begin @(posedge ACLK); #1; cyc++; end
    check_val("t6_in_wr_b", {31'b0, M_AXI_BREADY}, 32'd1);
    #2 ARESET = 1'b1;
    #1;
    check_val("t6_valids", {29'b0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 32'd0);
    check_val("t6_readies", {30'b0, M_AXI_BREADY, M_AXI_RREADY}, 32'd0);
    check_val("t6_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_val("t6_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    b_hold = 1'b0;
    @(posedge ACLK); #1;
    do_cmd(1'b1, 8'h04, 32'hAA, 0, rd, rr, rw, lat, fv);
    check_val("t6_wr_latency", lat, 32'd2);
    check_val("t6_wr_resp", {30'b0, rr}, 32'd0);
    do_cmd(1'b0, 8'h04, 32'h0, 0, rd, rr, rw, lat, fv);
    check_val("t6_rd_data", rd, 32'hAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
